pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program counter and micro-step sequencer for the accumulator CPU. It supplies the instruction address and the per-instruction step (T-state) count to the control decoder. It supports absolute and accumulator-indirect jumps, conditional and unconditional. It adds a call/return stack, halt/resume and stack error flags. Everything is fully synchronous in one clock domain; no derived clocks.

Parameters:
ADDR_W, 4, program counter width; pc wraps modulo 2**ADDR_W.
DATA_W, 4, accumulator width for indirect jump targets.
STEPS, 16, micro-steps per instruction (>=2).
STEP_W, $clog2(STEPS), width of the step output (derived; do not override).
STACK_DEPTH, 4, return-address stack entries (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  advance enable; when low, all state holds and requests are ignored.
jmp_req  in  1  jump request, sampled every enabled cycle.
jmp_cond  in  1  1 = jump is conditional on flag; 0 = unconditional.
flag  in  1  ALU condition flag.
jmp_sel  in  1  target select: 0 = jmp_addr, 1 = acc_in.
jmp_addr  in  ADDR_W  immediate target.
acc_in  in  DATA_W  accumulator target; zero-extended or truncated (LSBs kept) to ADDR_W.
call_req  in  1  call to selected target, pushing the return address.
ret_req  in  1  return, popping the return address.
halt  in  1  halt request.
resume  in  1  leave halted state.
pc  out  ADDR_W  current instruction address.
step  out  STEP_W  current micro-step, 0..STEPS-1.
instr_strobe  out  1  one-cycle pulse when a new instruction starts (step becomes 0).
halted  out  1  sequencer frozen.
stack_ovf  out  1  sticky: call attempted with stack full.
stack_unf  out  1  sticky: return attempted with stack empty.

Behaviour:
- Reset (async assert, sync release): pc=0, step=0, stack empty, halted=0, instr_strobe=0, stack_ovf=0, stack_unf=0. Reset mid-instruction discards all state immediately.
- Active cycle = en && !halted. Outside active cycles, pc, step, stack and strobe hold; instr_strobe=0.
- Sequential: step increments each active cycle. At step==STEPS-1, the next edge sets step=0 and pc=pc+1 (2**ADDR_W-1 wraps to 0). instr_strobe=1 in the cycle after that edge.
- Target = jmp_sel ? resize(acc_in) : jmp_addr. Taken = !jmp_cond || flag.
- Priority per active cycle: ret_req > call_req > jmp_req > sequential. Lower-priority requests in the same cycle are dropped.
- ret: stack non-empty -> pc=pop, step=0, strobe next cycle. Empty -> stack_unf=1, treat as sequential.
- call (taken condition applies): stack not full -> push pc+1 (mod 2**ADDR_W), pc=target, step=0. Full -> stack_ovf=1, no push, no jump, sequential. Not taken -> sequential.
- jmp taken: pc=target, step=0, strobe next cycle. Not taken: sequential.
- A redirect may occur at any step. Latency is 1 edge from request to new pc.
- halt (requires en) while not halted: at the next edge, halted=1 and that cycle's other requests are ignored. resume while halted: halted=0 at the next edge, and execution continues from the frozen pc/step. halt and resume together: halt wins.
- Sticky flags clear only on reset. Stack is LIFO with depth STACK_DEPTH; the full/empty count is ceil-free 0..STACK_DEPTH.

Test Plan:
1. Reset, en=1, no requests for 256 cycles -> pc steps 0..15 every 16 cycles and wraps to 0; instr_strobe pulses 16 times; step ramps 0..15.
2. At pc=3, step=5: jmp_req, jmp_cond=1, flag=0, jmp_addr=9 -> not taken, step=6. Repeat with flag=1 -> next cycle pc=9, step=0, strobe=1.
3. jmp_req, jmp_sel=1, acc_in=0xC, unconditional -> pc=0xC, step=0.
4. Five successive calls from pc=1,2,3,4,5 to 0xA -> first four push 2,3,4,5; fifth sets stack_ovf=1 and pc advances sequentially. Then four rets -> pc=5,4,3,2; fifth ret sets stack_unf=1.
5. ret_req+call_req+jmp_req in the same cycle with stack holding 7 -> pc=7, stack empty, no push.
6. Assert halt at step=4 -> pc/step frozen 20 cycles, halted=1. resume -> step=5 next. Assert rst_n=0 mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and micro-step (T-state) sequencer for the
// accumulator CPU. Supplies the instruction address and step count to the
// control decoder and handles absolute/indirect jumps, call/return through a
// small LIFO of return addresses, halt/resume, and sticky stack error flags.
module pc_sequencer #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 4,
   parameter int STEPS       = 16,
   parameter int STEP_W      = $clog2(STEPS),
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              jmp_req,
   input  logic              jmp_cond,
   input  logic              flag,
   input  logic              jmp_sel,
   input  logic [ADDR_W-1:0] jmp_addr,
   input  logic [DATA_W-1:0] acc_in,
   input  logic              call_req,
   input  logic              ret_req,
   input  logic              halt,
   input  logic              resume,
   output logic [ADDR_W-1:0] pc,
   output logic [STEP_W-1:0] step,
   output logic              instr_strobe,
   output logic              halted,
   output logic              stack_ovf,
   output logic              stack_unf
);

   // Stack depth counter spans 0..STACK_DEPTH inclusive, so it needs one more
   // code than the entry index.
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(STACK_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              strobe_q, strobe_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, unf_q;
   logic              ovf_set, unf_set;
   logic              push;
   logic              advance;

   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [ADDR_W-1:0] stack_top;

   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] pc_inc;
   logic              taken;
   logic              full;
   logic              empty;

   // Accumulator targets are resized to the address width: LSBs kept,
   // zero-extended when narrower.
   assign target    = jmp_sel ? ADDR_W'(acc_in) : jmp_addr;
   assign taken     = !jmp_cond || flag;
   assign pc_inc    = pc_q + PC_ONE;
   assign full      = (cnt_q == FULL_CNT);
   assign empty     = (cnt_q == '0);
   assign wr_idx    = IDX_W'(cnt_q);
   assign rd_idx    = IDX_W'(cnt_q - CNT_ONE);
   assign stack_top = stack_mem[rd_idx];

   // State register: pc, step, strobe, stack depth, run/halt state, sticky flags.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_RUN;
         pc_q     <= '0;
         step_q   <= '0;
         strobe_q <= 1'b0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         step_q   <= step_d;
         strobe_q <= strobe_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_q | ovf_set;
         unf_q    <= unf_q | unf_set;
      end
   end

   // Return-address storage: a push writes the slot just above the current top.
   // NOTE: the array is deliberately not reset; the depth counter alone says
   // which entries are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_mem[wr_idx] <= pc_inc;
      end
   end

   // Next-state logic: request priority ret > call > jmp > sequential, halt/resume.
   // NOTE: every signal written here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      step_d   = step_q;
      strobe_d = 1'b0;
      cnt_d    = cnt_q;
      push     = 1'b0;
      ovf_set  = 1'b0;
      unf_set  = 1'b0;
      advance  = 1'b0;

      case (state_q)
         S_RUN: begin
            if (en) begin
               advance = 1'b1;
               if (halt) begin
                  // Freeze at the current pc/step; same-cycle requests are dropped.
                  state_d = S_HALT;
                  advance = 1'b0;
               end else if (ret_req) begin
                  if (!empty) begin
                     pc_d     = stack_top;
                     step_d   = '0;
                     strobe_d = 1'b1;
                     cnt_d    = cnt_q - CNT_ONE;
                     advance  = 1'b0;
                  end else begin
                     unf_set = 1'b1;
                  end
               end else if (call_req) begin
                  if (taken && !full) begin
                     push     = 1'b1;
                     pc_d     = target;
                     step_d   = '0;
                     strobe_d = 1'b1;
                     cnt_d    = cnt_q + CNT_ONE;
                     advance  = 1'b0;
                  end else if (taken) begin
                     ovf_set = 1'b1;
                  end
               end else if (jmp_req && taken) begin
                  pc_d     = target;
                  step_d   = '0;
                  strobe_d = 1'b1;
                  advance  = 1'b0;
               end

               if (advance) begin
                  if (step_q == LAST_STEP) begin
                     step_d   = '0;
                     pc_d     = pc_inc;
                     strobe_d = 1'b1;
                  end else begin
                     step_d = step_q + STEP_ONE;
                  end
               end
            end
         end

         S_HALT: begin
            if (en && resume && !halt) begin
               state_d = S_RUN;
            end
         end

         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   assign pc           = pc_q;
   assign step         = step_q;
   assign instr_strobe = strobe_q;
   assign halted       = (state_q == S_HALT);
   assign stack_ovf    = ovf_q;
   assign stack_unf    = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized stimulus for pc_sequencer, checked
// every cycle against a queue-based behavioural model of the sequencer.
module tb_pc_sequencer;

   localparam int ADDR_W      = 4;
   localparam int DATA_W      = 4;
   localparam int STEPS       = 16;
   localparam int STEP_W      = $clog2(STEPS);
   localparam int STACK_DEPTH = 4;
   localparam int NPC         = 1 << ADDR_W;

   logic              clk;
   logic              rst_n;
   logic              en;
   logic              jmp_req;
   logic              jmp_cond;
   logic              flag;
   logic              jmp_sel;
   logic [ADDR_W-1:0] jmp_addr;
   logic [DATA_W-1:0] acc_in;
   logic              call_req;
   logic              ret_req;
   logic              halt;
   logic              resume;
   logic [ADDR_W-1:0] pc;
   logic [STEP_W-1:0] step;
   logic              instr_strobe;
   logic              halted;
   logic              stack_ovf;
   logic              stack_unf;

   int n_vec;
   int n_err;

   // Reference model state.
   int   m_pc;
   int   m_step;
   int   m_stack[$];
   bit   m_halted;
   bit   m_strobe;
   bit   m_ovf;
   bit   m_unf;

   pc_sequencer #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STEPS      (STEPS),
      .STACK_DEPTH(STACK_DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .jmp_req     (jmp_req),
      .jmp_cond    (jmp_cond),
      .flag        (flag),
      .jmp_sel     (jmp_sel),
      .jmp_addr    (jmp_addr),
      .acc_in      (acc_in),
      .call_req    (call_req),
      .ret_req     (ret_req),
      .halt        (halt),
      .resume      (resume),
      .pc          (pc),
      .step        (step),
      .instr_strobe(instr_strobe),
      .halted      (halted),
      .stack_ovf   (stack_ovf),
      .stack_unf   (stack_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc     = 0;
      m_step   = 0;
      m_stack.delete();
      m_halted = 0;
      m_strobe = 0;
      m_ovf    = 0;
      m_unf    = 0;
   endtask

   // One clock edge of the sequencer, computed directly from the rules.
   task automatic model_edge();
      int tgt;
      bit tk;
      bit seq;
      tgt      = jmp_sel ? (int'(acc_in) % NPC) : int'(jmp_addr);
      tk       = !jmp_cond || flag;
      seq      = 0;
      m_strobe = 0;
      if (!en) begin
         seq = 0;
      end else if (m_halted) begin
         if (resume && !halt) m_halted = 0;
      end else if (halt) begin
         m_halted = 1;
      end else if (ret_req) begin
         if (m_stack.size() > 0) begin
            m_pc     = m_stack.pop_back();
            m_step   = 0;
            m_strobe = 1;
         end else begin
            m_unf = 1;
            seq   = 1;
         end
      end else if (call_req) begin
         if (tk && m_stack.size() < STACK_DEPTH) begin
            m_stack.push_back((m_pc + 1) % NPC);
            m_pc     = tgt;
            m_step   = 0;
            m_strobe = 1;
         end else begin
            if (tk) m_ovf = 1;
            seq = 1;
         end
      end else if (jmp_req && tk) begin
         m_pc     = tgt;
         m_step   = 0;
         m_strobe = 1;
      end else begin
         seq = 1;
      end
      if (seq) begin
         m_step++;
         if (m_step == STEPS) begin
            m_step   = 0;
            m_pc     = (m_pc + 1) % NPC;
            m_strobe = 1;
         end
      end
   endtask

   task automatic check_all();
      check("pc",     32'(pc),           m_pc);
      check("step",   32'(step),         m_step);
      check("strobe", 32'(instr_strobe), 32'(m_strobe));
      check("halted", 32'(halted),       32'(m_halted));
      check("ovf",    32'(stack_ovf),    32'(m_ovf));
      check("unf",    32'(stack_unf),    32'(m_unf));
   endtask

   // Apply the inputs currently set, advance one edge, compare, return at negedge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic idle();
      en       = 1'b1;
      jmp_req  = 1'b0;
      jmp_cond = 1'b0;
      flag     = 1'b0;
      jmp_sel  = 1'b0;
      jmp_addr = '0;
      acc_in   = '0;
      call_req = 1'b0;
      ret_req  = 1'b0;
      halt     = 1'b0;
      resume   = 1'b0;
   endtask

   task automatic jump_to(input int addr);
      idle();
      jmp_req  = 1'b1;
      jmp_addr = ADDR_W'(addr);
      tick();
      idle();
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic randomize_inputs(input bit allow_halt);
      en       = ($urandom_range(0, 9) != 0);
      halt     = allow_halt && ($urandom_range(0, 39) == 0);
      resume   = allow_halt && ($urandom_range(0, 3) == 0);
      ret_req  = ($urandom_range(0, 7) == 0);
      call_req = ($urandom_range(0, 7) == 0);
      jmp_req  = ($urandom_range(0, 5) == 0);
      jmp_cond = 1'($urandom_range(0, 1));
      flag     = 1'($urandom_range(0, 1));
      jmp_sel  = 1'($urandom_range(0, 1));
      jmp_addr = ADDR_W'($urandom);
      acc_in   = DATA_W'($urandom);
   endtask

   initial begin
      int n_strobe;
      int budget;
      n_vec = 0;
      n_err = 0;
      idle();
      rst_n = 1'b0;
      model_reset();
      #3;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Free-running: 256 cycles sweep every address and wrap to 0.
      n_strobe = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         if (instr_strobe) n_strobe++;
      end
      check("free_strobes", 32'(n_strobe), 32'd16);
      check("free_wrap_pc", 32'(pc), 32'd0);

      // Reach pc=3, step=5, then conditional jump not taken / taken.
      budget = 0;
      while (!(m_pc == 3 && m_step == 5) && budget < 200) begin
         tick();
         budget++;
      end
      check("reach_pc3_step5", 32'(budget < 200), 32'd1);
      jmp_req  = 1'b1;
      jmp_cond = 1'b1;
      flag     = 1'b0;
      jmp_addr = 4'd9;
      tick();
      check("jmp_nt_pc", 32'(pc), 32'd3);
      check("jmp_nt_step", 32'(step), 32'd6);
      flag = 1'b1;
      tick();
      check("jmp_t_pc", 32'(pc), 32'd9);
      check("jmp_t_step", 32'(step), 32'd0);
      check("jmp_t_strobe", 32'(instr_strobe), 32'd1);
      idle();

      // Accumulator-indirect unconditional jump.
      jmp_req = 1'b1;
      jmp_sel = 1'b1;
      acc_in  = 4'hC;
      tick();
      check("ind_pc", 32'(pc), 32'hC);
      check("ind_step", 32'(step), 32'd0);
      idle();

      // Five calls from pc 1..5 to 0xA; the fifth overflows.
      for (int k = 1; k <= 5; k++) begin
         jump_to(k);
         call_req = 1'b1;
         jmp_addr = 4'hA;
         tick();
         idle();
         if (k <= STACK_DEPTH) check("call_pc", 32'(pc), 32'hA);
      end
      check("call_ovf_pc", 32'(pc), 32'd5);
      check("call_ovf_flag", 32'(stack_ovf), 32'd1);
      for (int k = 5; k >= 2; k--) begin
         ret_req = 1'b1;
         tick();
         check("ret_pc", 32'(pc), 32'(k));
      end
      tick();
      check("ret_unf_flag", 32'(stack_unf), 32'd1);
      check("ret_unf_pc", 32'(pc), 32'd2);
      idle();

      // ret beats call and jmp in the same cycle.
      jump_to(6);
      call_req = 1'b1;
      jmp_addr = 4'hA;
      tick();
      idle();
      ret_req  = 1'b1;
      call_req = 1'b1;
      jmp_req  = 1'b1;
      jmp_addr = 4'hB;
      tick();
      check("prio_pc", 32'(pc), 32'd7);
      idle();
      ret_req = 1'b1;
      tick();
      check("prio_empty_pc", 32'(pc), 32'd7);
      check("prio_empty_step", 32'(step), 32'd1);
      idle();

      // Halt at step 4, stay frozen through 20 cycles of ignored requests, resume.
      budget = 0;
      while (m_step != 4 && budget < 40) begin
         tick();
         budget++;
      end
      halt = 1'b1;
      tick();
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_step", 32'(step), 32'd4);
      for (int i = 0; i < 20; i++) begin
         randomize_inputs(1'b0);
         en = 1'b1;
         tick();
      end
      check("frozen_step", 32'(step), 32'd4);
      idle();
      resume = 1'b1;
      tick();
      check("resume_flag", 32'(halted), 32'd0);
      idle();
      tick();
      check("resume_step", 32'(step), 32'd5);

      // Randomized traffic with an asynchronous reset in the middle.
      for (int i = 0; i < 1500; i++) begin
         randomize_inputs(1'b1);
         tick();
         if (i == 700) begin
            idle();
            async_reset();
            check("rst_pc", 32'(pc), 32'd0);
         end
      end
      idle();
      async_reset();
      check("final_rst_step", 32'(step), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
